// File: rtl/pipe_elastic_3.sv
// Three-stage elastic pipeline with valid/ready handshake and synchronous flush.
// Latency: a word accepted on one edge is on q3 after the second following edge.
// Backpressure: ready ripples combinationally from out_ready; stages fill while stalled.
// Optional feature macro: PIPE_ELASTIC_OCC_EN adds a registered 2-bit occupancy output occ.
module pipe_elastic_3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] q3,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_ELASTIC_OCC_EN
  ,
  output logic [1:0]       occ
`endif
);

  logic             s1_vld_q, s2_vld_q, s3_vld_q;
  logic             s1_vld_d, s2_vld_d, s3_vld_d;
  logic [WIDTH-1:0] s1_dat_q, s2_dat_q, s3_dat_q;
  logic [WIDTH-1:0] s1_dat_d, s2_dat_d, s3_dat_d;
  logic             en1, en2, en3;

  // Load enables: a stage may load when empty or when its content moves on this cycle.
  always_comb begin
    en3      = !s3_vld_q || out_ready;
    en2      = !s2_vld_q || en3;
    en1      = !s1_vld_q || en2;
    in_ready = !flush && en1;
  end

  // Next-state for valid bits and data; data only moves with a valid word so
  // empty stages keep their last contents.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    s3_vld_d = s3_vld_q;
    s1_dat_d = s1_dat_q;
    s2_dat_d = s2_dat_q;
    s3_dat_d = s3_dat_q;
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
      s3_vld_d = 1'b0;
    end else begin
      if (en3) begin
        s3_vld_d = s2_vld_q;
        if (s2_vld_q) s3_dat_d = s2_dat_q;
      end
      if (en2) begin
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) s2_dat_d = s1_dat_q;
      end
      if (en1) begin
        s1_vld_d = in_valid;
        if (in_valid) s1_dat_d = d;
      end
    end
  end

  // Stage registers; reset clears both valid bits and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_dat_q <= '0;
      s3_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_dat_q <= s1_dat_d;
      s2_dat_q <= s2_dat_d;
      s3_dat_q <= s3_dat_d;
    end
  end

  assign out_valid = s3_vld_q;
  assign q3        = s3_dat_q;

`ifdef PIPE_ELASTIC_OCC_EN
  logic [1:0] occ_q, occ_d;

  // Occupancy follows the next valid bits so it changes on the same edge.
  always_comb begin
    occ_d = {1'b0, s1_vld_d} + {1'b0, s2_vld_d} + {1'b0, s3_vld_d};
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= 2'd0;
    else        occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_elastic_3.sv
module tb_pipe_elastic_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] q3;
  logic       out_valid;
  logic       out_ready;
`ifdef PIPE_ELASTIC_OCC_EN
  logic [1:0] occ;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  pipe_elastic_3 #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d(d),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .q3(q3),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PIPE_ELASTIC_OCC_EN
    ,
    .occ(occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, score handshakes mid-low-phase, advance to next negedge.
  // exp_ir < 0 skips the in_ready check.
  task automatic cyc(input logic iv, input logic [7:0] dd, input logic ordy,
                     input logic fl, input int exp_ir);
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
    flush     = fl;
    #2;
    if (exp_ir >= 0) chk("in_ready", {31'd0, in_ready}, exp_ir[31:0]);
`ifdef PIPE_ELASTIC_OCC_EN
    chk("occ", {30'd0, occ}, sb.size());
`endif
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out: observed q3=%0h expected no output", q3);
      end
      if (sb.size() != 0) chk("out_data", {24'd0, q3}, {24'd0, sb.pop_front()});
    end
    if (in_valid && in_ready) sb.push_back(d);
    @(posedge clk);
    if (fl) sb.delete();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; d = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_q3", {24'd0, q3}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 0x11..0x44 back to back, out_ready high.
    cyc(1, 8'h11, 1, 0, 1); chk("lat_e1_vld", {31'd0, out_valid}, 0);
    cyc(1, 8'h22, 1, 0, 1); chk("lat_e2_vld", {31'd0, out_valid}, 0);
    cyc(1, 8'h33, 1, 0, 1); chk("lat_e3_vld", {31'd0, out_valid}, 1);
    chk("lat_e3_q3", {24'd0, q3}, 32'h11);
    cyc(1, 8'h44, 1, 0, 1); chk("stream_vld4", {31'd0, out_valid}, 1);
    cyc(0, 8'h00, 1, 0, 1); chk("stream_vld5", {31'd0, out_valid}, 1);
    cyc(0, 8'h00, 1, 0, 1); chk("stream_vld6", {31'd0, out_valid}, 1);
    chk("stream_q3_6", {24'd0, q3}, 32'h44);
    cyc(0, 8'h00, 1, 0, 1); chk("stream_drained", {31'd0, out_valid}, 0);

    // Backpressure: fill with out_ready low, fourth word refused.
    cyc(1, 8'hA1, 0, 0, 1);
    cyc(1, 8'hA2, 0, 0, 1);
    cyc(1, 8'hA3, 0, 0, 1);
    chk("bp_head", {24'd0, q3}, 32'hA1);
    cyc(1, 8'hA4, 0, 0, 0);
    chk("bp_hold_vld", {31'd0, out_valid}, 1);
    chk("bp_hold_q3", {24'd0, q3}, 32'hA1);
`ifdef PIPE_ELASTIC_OCC_EN
    chk("bp_occ3", {30'd0, occ}, 3);
`endif
    cyc(1, 8'hA4, 1, 0, 1);
    chk("bp_q3_next", {24'd0, q3}, 32'hA2);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("bp_drained", {31'd0, out_valid}, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Full pipe with simultaneous accept and emit.
    cyc(1, 8'hB1, 0, 0, 1);
    cyc(1, 8'hB2, 0, 0, 1);
    cyc(1, 8'hB3, 0, 0, 1);
    cyc(1, 8'h5C, 1, 0, 1);
    chk("full_q3", {24'd0, q3}, 32'hB2);
    chk("full_sb3", sb.size(), 3);
`ifdef PIPE_ELASTIC_OCC_EN
    chk("full_occ3", {30'd0, occ}, 3);
`endif
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("full_last_q3", {24'd0, q3}, 32'h5C);
    cyc(0, 8'h00, 1, 0, 1);
    chk("full_drained", sb.size(), 0);

    // Flush with two words held and a third offered.
    cyc(1, 8'h01, 0, 0, 1);
    cyc(1, 8'h02, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, -1);
    chk("fl_pre_vld", {31'd0, out_valid}, 1);
    cyc(1, 8'h03, 0, 1, 0);
    chk("fl_post_vld", {31'd0, out_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0, 1);
      chk("fl_no_out", {31'd0, out_valid}, 0);
    end

    // Asynchronous reset with two words in flight.
    cyc(1, 8'hC1, 1, 0, 1);
    cyc(1, 8'hC2, 1, 0, 1);
    in_valid = 1'b0;
    cyc(0, 8'h00, 1, 0, 1);
    chk("rs_pre_vld", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_vld", {31'd0, out_valid}, 0);
    chk("rs_async_q3", {24'd0, q3}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h7E, 1, 0, 1); chk("rs_e1_vld", {31'd0, out_valid}, 0);
    cyc(0, 8'h00, 1, 0, 1); chk("rs_e2_vld", {31'd0, out_valid}, 0);
    cyc(0, 8'h00, 1, 0, 1); chk("rs_e3_vld", {31'd0, out_valid}, 1);
    chk("rs_e3_q3", {24'd0, q3}, 32'h7E);
    cyc(0, 8'h00, 1, 0, 1);
    chk("rs_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
